// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 timing constants, colour type and a range helper shared with render logic.
package vga_timing_pkg;
  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int CW       = 12;
  typedef logic [CW-1:0] rgb_t;
  function automatic logic in_range(int v, int lo, int hi);
    return (v >= lo) && (v < hi);
  endfunction
endpackage

// File: rtl/pixel_prescaler.sv
// pixel_prescaler: divides clk by DIV into a registered one-cycle pixel-advance strobe.
module pixel_prescaler #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic pix_tick_o
);
  localparam int PW = $clog2(DIV);
  logic [PW-1:0] pre_q, pre_d;
  logic          tick_q;
  logic          last;
  assign last = pre_q == PW'(DIV - 1);
  always_comb pre_d = last ? '0 : pre_q + 1'b1;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      tick_q <= last;
    end
  end
  assign pix_tick_o = tick_q;
endmodule

// File: rtl/vga_sync.sv
// vga_sync: VGA raster counters with a one-pixel-delayed registered sync/DE/RGB output stage.
module vga_sync
  import vga_timing_pkg::*;
#(
  parameter int DIV      = 4,
  parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
  parameter int H_FP     = vga_timing_pkg::H_FP,
  parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter int H_BP     = vga_timing_pkg::H_BP,
  parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
  parameter int V_FP     = vga_timing_pkg::V_FP,
  parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter int V_BP     = vga_timing_pkg::V_BP,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CW-1:0] rgb_in,
  output logic [9:0]    x,
  output logic [9:0]    y,
  output logic          pix_tick,
  output logic          line_start,
  output logic          frame_start,
  output logic          hs,
  output logic          vs,
  output logic          de,
  output logic [CW-1:0] rgb_out
);
  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  logic [9:0] h_q, h_d, v_q, v_d;
  logic       hs_q, vs_q, de_q;
  rgb_t       rgb_q;
  logic       h_end, v_end, active, hs_act, vs_act;
  pixel_prescaler #(.DIV(DIV)) u_pre (
    .clk        (clk),
    .rst        (rst),
    .pix_tick_o (pix_tick)
  );
  assign h_end  = h_q == 10'(HT - 1);
  assign v_end  = v_q == 10'(VT - 1);
  assign active = in_range(int'(h_q), 0, H_ACTIVE) && in_range(int'(v_q), 0, V_ACTIVE);
  assign hs_act = in_range(int'(h_q), H_ACTIVE + H_FP, H_ACTIVE + H_FP + H_SYNC);
  assign vs_act = in_range(int'(v_q), V_ACTIVE + V_FP, V_ACTIVE + V_FP + V_SYNC);
  always_comb begin
    h_d = !pix_tick ? h_q : h_end ? '0 : h_q + 1'b1;
    v_d = !(pix_tick && h_end) ? v_q : v_end ? '0 : v_q + 1'b1;
  end
  // Output stage samples the pre-advance position, so it trails x/y by one pixel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_q   <= '0;
      v_q   <= '0;
      hs_q  <= !SYNC_POL;
      vs_q  <= !SYNC_POL;
      de_q  <= 1'b0;
      rgb_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
      if (pix_tick) begin
        hs_q  <= hs_act ? SYNC_POL : !SYNC_POL;
        vs_q  <= vs_act ? SYNC_POL : !SYNC_POL;
        de_q  <= active;
        rgb_q <= active ? rgb_in : '0;
      end
    end
  end
  assign x           = h_q;
  assign y           = v_q;
  assign line_start  = pix_tick && h_end;
  assign frame_start = line_start && v_end;
  assign hs          = hs_q;
  assign vs          = vs_q;
  assign de          = de_q;
  assign rgb_out     = rgb_q;
endmodule
